ram_bus_arbiter: RTL

//  Shares one RamBus register-file port in the DM interface fabric between two MSS APB slave

---
 rtl/ram_bus_arbiter.sv | 163 ++++++++++++++++
 1 files changed

// File: rtl/ram_bus_arbiter.sv
// ============================================================================
// Module   : ram_bus_arbiter
// Purpose  : Round-robin share of one RamBus port between two APB requesters,
//            with access re-timing and dead-slave timeout.
// Revision : 1.0
// ============================================================================
`default_nettype none

module ram_bus_arbiter #(
  parameter int                ADDR_W       = 14,
  parameter int                DATA_W       = 32,
  parameter int                TIMEOUT_CYC  = 1024,
  parameter logic [DATA_W-1:0] TIMEOUT_DATA = 'hDEADBEEF
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              RamBusnCs0,
  input  logic              RamBusWrnRd0,
  input  logic              RamBusLatch0,
  input  logic [ADDR_W-1:0] RamBusAddress0,
  input  logic [DATA_W-1:0] RamBusDataIn0,
  output logic [DATA_W-1:0] RamBusDataOut0,
  output logic              RamBusAck0,
  input  logic              RamBusnCs1,
  input  logic              RamBusWrnRd1,
  input  logic              RamBusLatch1,
  input  logic [ADDR_W-1:0] RamBusAddress1,
  input  logic [DATA_W-1:0] RamBusDataIn1,
  output logic [DATA_W-1:0] RamBusDataOut1,
  output logic              RamBusAck1,
  output logic              DsnCs,
  output logic              DsWrnRd,
  output logic              DsLatch,
  output logic [ADDR_W-1:0] DsAddress,
  output logic [DATA_W-1:0] DsDataIn,
  input  logic [DATA_W-1:0] DsDataOut,
  input  logic              DsAck,
  output logic              Grant,
  output logic              Busy,
  output logic [15:0]       TimeoutCount
);

  localparam int            c_cntW   = (TIMEOUT_CYC > 2) ? $clog2(TIMEOUT_CYC) : 1;
  localparam logic [c_cntW-1:0] c_cntMax = c_cntW'(TIMEOUT_CYC - 1);

  typedef enum logic [1:0] {
    S_IDLE   = 2'd0,
    S_SETUP  = 2'd1,
    S_ACCESS = 2'd2,
    S_RESP   = 2'd3
  } state_t;

  state_t              r_state;
  state_t              w_nextState;
  logic                r_pointer;
  logic                r_grant;
  logic                r_ack0;
  logic                r_ack1;
  logic                r_dsWrnRd;
  logic [ADDR_W-1:0]   r_dsAddress;
  logic [DATA_W-1:0]   r_dsDataIn;
  logic [DATA_W-1:0]   r_dataOut0;
  logic [DATA_W-1:0]   r_dataOut1;
  logic [c_cntW-1:0]   r_cnt;
  logic [15:0]         r_timeoutCount;

  logic                w_req0;
  logic                w_req1;
  logic                w_pick;
  logic                w_cntEnd;
  logic                w_accessDone;
  logic [DATA_W-1:0]   w_readData;

  assign w_req0       = RamBusnCs0 & RamBusLatch0;
  assign w_req1       = RamBusnCs1 & RamBusLatch1;
  // Contention goes to the pointer port; otherwise whichever port asks.
  assign w_pick       = (w_req0 & w_req1) ? r_pointer : w_req1;
  assign w_cntEnd     = (r_cnt == c_cntMax);
  assign w_accessDone = (r_state == S_ACCESS) & (DsAck | w_cntEnd);
  assign w_readData   = DsAck ? DsDataOut : TIMEOUT_DATA;

  always_ff @(posedge clk) begin
    if (rst) begin
      r_state <= S_IDLE;
    end else begin
      r_state <= w_nextState;
    end
  end

  always_comb begin
    w_nextState = r_state;
    case (r_state)
      S_IDLE:   if (w_req0 | w_req1) w_nextState = S_SETUP;
      S_SETUP:  w_nextState = S_ACCESS;
      S_ACCESS: if (w_accessDone) w_nextState = S_RESP;
      S_RESP:   w_nextState = S_IDLE;
      default:  w_nextState = S_IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      r_pointer      <= 1'b0;
      r_grant        <= 1'b0;
      r_ack0         <= 1'b0;
      r_ack1         <= 1'b0;
      r_dsWrnRd      <= 1'b0;
      r_dsAddress    <= '0;
      r_dsDataIn     <= '0;
      r_dataOut0     <= '0;
      r_dataOut1     <= '0;
      r_cnt          <= '0;
      r_timeoutCount <= '0;
    end else begin
      r_ack0 <= 1'b0;
      r_ack1 <= 1'b0;
      case (r_state)
        S_IDLE: begin
          if (w_req0 | w_req1) begin
            r_grant     <= w_pick;
            r_dsWrnRd   <= w_pick ? RamBusWrnRd1   : RamBusWrnRd0;
            r_dsAddress <= w_pick ? RamBusAddress1 : RamBusAddress0;
            r_dsDataIn  <= w_pick ? RamBusDataIn1  : RamBusDataIn0;
          end
        end
        S_SETUP: r_cnt <= '0;
        S_ACCESS: begin
          r_cnt <= r_cnt + 1'b1;
          if (w_accessDone) begin
            r_ack0 <= ~r_grant;
            r_ack1 <= r_grant;
            if (!r_dsWrnRd) begin
              if (r_grant) r_dataOut1 <= w_readData;
              else         r_dataOut0 <= w_readData;
            end
            // An ack on the last permitted cycle is a normal completion.
            if (!DsAck && r_timeoutCount != 16'hFFFF) begin
              r_timeoutCount <= r_timeoutCount + 16'd1;
            end
          end
        end
        S_RESP: r_pointer <= ~r_grant;
        default: ;
      endcase
    end
  end

  assign DsnCs          = (r_state == S_SETUP) | (r_state == S_ACCESS);
  assign DsLatch        = (r_state == S_ACCESS);
  assign Busy           = (r_state != S_IDLE);
  assign DsWrnRd        = r_dsWrnRd;
  assign DsAddress      = r_dsAddress;
  assign DsDataIn       = r_dsDataIn;
  assign Grant          = r_grant;
  assign RamBusAck0     = r_ack0;
  assign RamBusAck1     = r_ack1;
  assign RamBusDataOut0 = r_dataOut0;
  assign RamBusDataOut1 = r_dataOut1;
  assign TimeoutCount   = r_timeoutCount;

endmodule

`default_nettype wire
